// File: rtl/alu_pkg.sv
// ============================================================================
// Module      : alu_pkg
// Description : Shared ALU result-path types: skid-buffer state and result entry.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam int ALU_WIDTH = 32;
    localparam int ALU_TAG_W = 4;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [ALU_WIDTH-1:0] result;
        logic [ALU_TAG_W-1:0] tag;
        logic                 carry;
        logic                 zero;
        logic                 neg;
    } entry_t;

endpackage

`default_nettype wire

// File: rtl/alu_flag_gen.sv
// ============================================================================
// Module      : alu_flag_gen
// Description : Combinational zero/negative flag generation for an ALU result.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_flag_gen #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             neg
);

    assign zero = (result == '0);
    assign neg  = result[WIDTH-1];

endmodule

`default_nettype wire

// File: rtl/alu_result_stage.sv
// ============================================================================
// Module      : alu_result_stage
// Description : Registered ALU result stage with 2-entry skid buffer and
//               delivered-result counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_result_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int TAG_W = ALU_TAG_W,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_result,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             in_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_zero,
    output logic             out_neg,
    output logic             out_carry,
    output logic [CNT_W-1:0] result_count
);

    state_t     state;
    state_t     state_nxt;
    entry_t     head;
    entry_t     skid;
    entry_t     in_entry;
    logic       in_zero;
    logic       in_neg;
    logic       accept;
    logic       deliver;
    logic       load_head_in;
    logic       load_head_skid;
    logic       load_skid;

    alu_flag_gen #(
        .WIDTH (WIDTH)
    ) u_flag_gen (
        .result (in_result),
        .zero   (in_zero),
        .neg    (in_neg)
    );

    assign in_entry = '{result: in_result, tag: in_tag, carry: in_carry,
                        zero: in_zero, neg: in_neg};

    // Ready is decoded purely from registered state so writeback stall never
    // forms a combinational path back to the producer.
    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign accept    = in_valid & in_ready;
    assign deliver   = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        load_head_in   = 1'b0;
        load_head_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state_nxt    = ONE;
                        load_head_in = 1'b1;
                    end
                end
                ONE: begin
                    if (accept && !deliver) begin
                        state_nxt = FULL;
                        load_skid = 1'b1;
                    end else if (!accept && deliver) begin
                        state_nxt = EMPTY;
                    end else if (accept && deliver) begin
                        load_head_in = 1'b1;
                    end
                end
                FULL: begin
                    if (deliver) begin
                        state_nxt      = ONE;
                        load_head_skid = 1'b1;
                    end
                end
                default: begin
                    state_nxt = EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            skid <= '0;
        end else begin
            if (load_head_in) begin
                head <= in_entry;
            end else if (load_head_skid) begin
                head <= skid;
            end
            if (load_skid) begin
                skid <= in_entry;
            end
        end
    end

    // A delivery in a flush cycle still counts: writeback consumed it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_count <= '0;
        end else if (deliver) begin
            result_count <= result_count + 1'b1;
        end
    end

    assign out_result = head.result;
    assign out_tag    = head.tag;
    assign out_zero   = head.zero;
    assign out_neg    = head.neg;
    assign out_carry  = head.carry;

endmodule

`default_nettype wire

// File: tb/tb_alu_result_stage.sv
// ============================================================================
// Module      : tb_alu_result_stage
// Description : Randomized self-checking bench for alu_result_stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_result_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_result;
    logic [3:0]  in_tag;
    logic        in_carry;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [3:0]  out_tag;
    logic        out_zero;
    logic        out_neg;
    logic        out_carry;
    logic [15:0] result_count;

    logic        w_in_ready;
    logic        w_out_valid;
    logic [31:0] w_out_result;
    logic [3:0]  w_out_tag;
    logic        w_out_zero;
    logic        w_out_neg;
    logic        w_out_carry;
    logic [3:0]  w_result_count;

    always #5 clk = ~clk;

    alu_result_stage #(.WIDTH(32), .TAG_W(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
        .in_tag(in_tag), .in_carry(in_carry),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_tag(out_tag), .out_zero(out_zero), .out_neg(out_neg),
        .out_carry(out_carry), .result_count(result_count)
    );

    // Narrow-counter instance shares all inputs to exercise counter wrap.
    alu_result_stage #(.WIDTH(32), .TAG_W(4), .CNT_W(4)) dut_w (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(w_in_ready), .in_result(in_result),
        .in_tag(in_tag), .in_carry(in_carry),
        .out_valid(w_out_valid), .out_ready(out_ready), .out_result(w_out_result),
        .out_tag(w_out_tag), .out_zero(w_out_zero), .out_neg(w_out_neg),
        .out_carry(w_out_carry), .result_count(w_result_count)
    );

    typedef struct {
        logic [31:0] result;
        logic [3:0]  tag;
        logic        carry;
    } item_t;

    item_t q[$];
    int    cnt = 0;
    int    vectors = 0;
    int    miscompares = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check("out_valid", 64'(out_valid), 64'(q.size() > 0));
        check("in_ready", 64'(in_ready), 64'(q.size() < 2));
        check("count", 64'(result_count), 64'(cnt % 65536));
        check("count_wrap", 64'(w_result_count), 64'(cnt % 16));
        check("w_out_valid", 64'(w_out_valid), 64'(q.size() > 0));
        if (q.size() > 0) begin
            check("out_result", 64'(out_result), 64'(q[0].result));
            check("out_tag", 64'(out_tag), 64'(q[0].tag));
            check("out_carry", 64'(out_carry), 64'(q[0].carry));
            check("out_zero", 64'(out_zero), 64'(q[0].result == 32'd0));
            check("out_neg", 64'(out_neg), 64'(q[0].result >= 32'h8000_0000));
        end
    endtask

    // Called just after a falling edge: check, drive, advance one clock.
    task automatic cycle(input logic v, input logic r, input logic f,
                         input logic [31:0] d, input logic [3:0] t, input logic c);
        bit acc;
        bit del;
        item_t e;
        check_outputs();
        in_valid  = v;
        out_ready = r;
        flush     = f;
        in_result = v ? d : 32'hDEAD_BEEF;
        in_tag    = t;
        in_carry  = c;
        acc = v && (q.size() < 2);
        del = r && (q.size() > 0);
        e.result = d;
        e.tag    = t;
        e.carry  = c;
        @(posedge clk);
        if (del) begin
            void'(q.pop_front());
            cnt++;
        end
        if (f) q.delete();
        else if (acc) q.push_back(e);
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_data();
        case ($urandom_range(0, 3))
            0:       return 32'd0;
            1:       return 32'h8000_0000 | $urandom;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_result = '0; in_tag = '0; in_carry = 1'b0;
        @(negedge clk); @(negedge clk);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_ready", 64'(in_ready), 64'd1);
        check("rst_result", 64'(out_result), 64'd0);
        check("rst_flags", 64'({out_tag, out_zero, out_neg, out_carry}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single transfer with 1-cycle latency.
        cycle(1, 1, 0, 32'h8000_0000, 4'd3, 0);
        check("lat_neg", 64'(out_neg), 64'd1);
        cycle(0, 1, 0, 0, 0, 0);
        check("cnt_one", 64'(result_count), 64'd1);

        // Backpressure fill then drain in order.
        cycle(1, 0, 0, 32'h0, 4'd1, 0);
        cycle(1, 0, 0, 32'h1, 4'd2, 1);
        check("full_ready", 64'(in_ready), 64'd0);
        cycle(0, 0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0);
        check("drained_ready", 64'(in_ready), 64'd1);

        // Streaming: never reaches FULL.
        for (int i = 0; i < 20; i++) begin
            cycle(1, 1, 0, 32'(i + 100), 4'(i), 0);
            check("stream_ready", 64'(in_ready), 64'd1);
        end
        cycle(0, 1, 0, 0, 0, 0);

        // Flush while FULL with an incoming entry.
        cycle(1, 0, 0, 32'h55, 4'd5, 0);
        cycle(1, 0, 0, 32'h66, 4'd6, 0);
        cycle(1, 0, 1, 32'h77, 4'd7, 0);
        check("flush_valid", 64'(out_valid), 64'd0);
        cycle(0, 1, 0, 0, 0, 0);

        // Async reset between clock edges.
        cycle(1, 0, 0, 32'hABCD_0001, 4'd9, 1);
        cycle(1, 0, 0, 32'hABCD_0002, 4'd8, 1);
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", 64'(out_valid), 64'd0);
        check("arst_result", 64'(out_result), 64'd0);
        check("arst_flags", 64'({out_tag, out_zero, out_neg, out_carry}), 64'd0);
        check("arst_count", 64'(result_count), 64'd0);
        q.delete();
        cnt = 0;
        in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1, 0, 0, 32'h1234_5678, 4'd4, 0);
        check("post_rst_lat", 64'(out_valid), 64'd1);

        // 17 deliveries for the narrow counter wrap.
        for (int i = 0; i < 17; i++) cycle(1, 1, 0, 32'(i), 4'(i), 0);
        cycle(0, 1, 0, 0, 0, 0);
        check("wrap17", 64'(w_result_count), 64'd2);

        // Randomized phases with varying valid/ready/flush pressure.
        for (int p = 0; p < 6; p++) begin
            int pv = $urandom_range(20, 100);
            int pr = $urandom_range(10, 100);
            for (int i = 0; i < 400; i++) begin
                cycle($urandom_range(1, 100) <= pv, $urandom_range(1, 100) <= pr,
                      $urandom_range(0, 40) == 0, rand_data(),
                      4'($urandom), 1'($urandom));
            end
        end
        check_outputs();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Registered output stage directly downstream of the combinational right-shifter and the other ALU datapaths. It captures the selected WIDTH-bit result plus a tag and carry.
- It generates zero and negative flags at capture.
- It presents result and flags to writeback through a valid/ready handshake, backed by a 2-entry skid buffer, so the shifter path stays purely combinational and writeback backpressure never creates a combinational ready path.
- It also keeps a wrapping count of delivered results for debug and performance monitoring.

Parameters:
- WIDTH, 32: datapath width of result; must equal the shifter width.
- TAG_W, 4: width of the opaque op/destination tag carried alongside each result.
- CNT_W, 16: width of the delivered-result counter.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous; discards all buffered and incoming results
- in_valid  input  1  upstream result valid
- in_ready  output  1  stage can accept a result this cycle
- in_result  input  WIDTH  result from shifter/ALU mux
- in_tag  input  TAG_W  tag travelling with result
- in_carry  input  1  carry/borrow from the producing unit (0 for shifts)
- out_valid  output  1  buffered result available
- out_ready  input  1  writeback accepts this cycle
- out_result  output  WIDTH  head result
- out_tag  output  TAG_W  head tag
- out_zero  output  1  head result == 0
- out_neg  output  1  head result[WIDTH-1]
- out_carry  output  1  head carry
- result_count  output  CNT_W  number of output handshakes since reset, wrapping

Behaviour:
- Clock and reset: one clock domain; reset is asynchronous and active-low.
- Reset values: state EMPTY; out_valid=0; out_result, out_tag, out_zero, out_neg, out_carry all 0; result_count=0; in_ready=1 (decoded from EMPTY).
- Handshake rules:
  - Accept = in_valid & in_ready.
  - Deliver = out_valid & out_ready.
  - in_ready depends only on registered state (state != FULL); it never depends combinationally on out_ready.
- Flag generation: out_zero = (result == 0) and out_neg = result[WIDTH-1], both computed from in_result at accept and stored with the entry. Flags are never recomputed from the output registers.
- Latency: an entry accepted in cycle N appears on out_* with out_valid=1 in cycle N+1 when the buffer was EMPTY.
- Ordering: strict FIFO order through both entries; the head is always the oldest entry.
- State machine, with head register H and skid register K:
  - EMPTY: Accept → ONE (load H).
  - ONE, Accept with no Deliver → FULL (load K).
  - ONE, Deliver with no Accept → EMPTY.
  - ONE, Accept and Deliver in the same cycle → stay ONE (load H with the new entry).
  - FULL: in_ready=0. Deliver → ONE (H <= K). No accept is possible.
- Stability: while out_valid=1 and out_ready=0, every out_* signal holds its value exactly.
- Don't-care rule: in_result, in_tag and in_carry are ignored when in_valid=0. Out_* values are don't-care when out_valid=0, but they hold their last value, never X.
- Flush:
  - Next state EMPTY and out_valid=0 the following cycle.
  - An Accept in the flush cycle is dropped.
  - A Deliver in the flush cycle still counts, because writeback took it.
  - flush has priority over all other transitions.
- Counter: result_count increments by 1 on each Deliver and wraps from all-ones to 0 with no saturation. It is not cleared by flush.
- Reset mid-operation: buffered entries are lost immediately and outputs go to their reset values asynchronously. No handshake may complete during reset.

Decomposition:
- Shared package alu_pkg holds:
  - the state enum (EMPTY, ONE, FULL),
  - the entry struct {result, tag, carry, zero, neg} parameterised through WIDTH/TAG_W localparams matching the shifter,
  - default WIDTH=32.
- One natural sub-module: alu_flag_gen, purely combinational, result → {zero, neg}. It is reused by later writeback/compare logic.
- The skid buffer stays inline.

Test Plan:
1. Reset then single transfer: in_result=32'h8000_0000, tag=3, out_ready=1 → one cycle later out_valid=1, out_result=32'h8000_0000, out_neg=1, out_zero=0, out_tag=3; result_count becomes 1 after the handshake.
2. Backpressure fill: out_ready=0, push 32'h0 then 32'h1 → out_zero=1 is held stable and in_ready=0 after the second accept. Raising out_ready delivers 32'h0 then 32'h1 in order, and in_ready returns to 1.
3. Streaming: in_valid=1 and out_ready=1 for 20 cycles with incrementing results → one result per cycle, state never reaches FULL, order is preserved, result_count=20.
4. Flush while FULL with in_valid=1 → next cycle out_valid=0, in_ready=1, the incoming entry is not delivered later, and result_count is unchanged.
5. Counter wrap with CNT_W=4: 17 deliveries → result_count reads 1.
6. Async reset asserted mid-stream between clock edges → out_valid and out_* go to 0 immediately. After release, the first accepted entry passes through with 1-cycle latency.
